// File: rtl/d5m_stream_gen_pkg.sv
// d5m_stream_gen_pkg
// Shared definitions for the D5M sensor-side stream generator:
//   DATA_W       - pixel width of the D5M data bus
//   state_t      - generator sequencing states
//   PAT_*        - pattern select codes carried on iPATTERN
//   BAYER_*      - fixed levels for the Bayer mosaic pattern
package d5m_stream_gen_pkg;

    localparam int DATA_W = 12;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FRONT  = 3'd1,
        LINE   = 3'd2,
        HBLANK = 3'd3,
        BACK   = 3'd4,
        VBLANK = 3'd5
    } state_t;

    localparam logic [1:0] PAT_HRAMP = 2'd0;
    localparam logic [1:0] PAT_VRAMP = 2'd1;
    localparam logic [1:0] PAT_BAYER = 2'd2;
    localparam logic [1:0] PAT_TAG   = 2'd3;

    localparam logic [DATA_W-1:0] BAYER_G = 12'h800;
    localparam logic [DATA_W-1:0] BAYER_R = 12'hFFF;
    localparam logic [DATA_W-1:0] BAYER_B = 12'h000;

endpackage

// File: rtl/d5m_pattern_lut.sv
// d5m_pattern_lut
// Combinational test-pattern generator; the parent registers the result.
// Ports:
//   pattern  in  2   pattern select (PAT_* codes)
//   x        in  12  pixel column
//   y        in  12  line number
//   f        in  4   low nibble of the completed-frame count
//   pixel    out 12  pixel value for (pattern, x, y, f)
module d5m_pattern_lut
    import d5m_stream_gen_pkg::*;
(
    input  logic [1:0]        pattern,
    input  logic [11:0]       x,
    input  logic [11:0]       y,
    input  logic [3:0]        f,
    output logic [DATA_W-1:0] pixel
);

    always_comb begin
        pixel = '0;
        case (pattern)
            PAT_HRAMP: pixel = x;
            PAT_VRAMP: pixel = y;
            PAT_BAYER: begin
                // Mosaic position is selected by the row/column parity.
                case ({y[0], x[0]})
                    2'b00:   pixel = BAYER_G;
                    2'b01:   pixel = BAYER_R;
                    2'b10:   pixel = BAYER_B;
                    default: pixel = BAYER_G;
                endcase
            end
            PAT_TAG:   pixel = {f, y[3:0], x[3:0]};
            default:   pixel = '0;
        endcase
    end

endmodule

// File: rtl/d5m_stream_gen.sv
// d5m_stream_gen
// D5M sensor-side pixel stream source producing FVAL/LVAL/12-bit data with
// programmable porches and blanking, in the format CCD_Capture consumes.
// Optional feature macro: STREAM_GEN_CHECKSUM_EN (per-frame data checksum).
// Ports:
//   iCLK         in  1   pixel clock, sole clock
//   iRST         in  1   synchronous active-high reset
//   iSTART       in  1   start request (level or pulse), honoured in IDLE only
//   iSTOP        in  1   stop request pulse; finishes the current frame first
//   iPATTERN     in  2   pattern select, latched at each frame start
//   oDATA        out 12  pixel data, 0 whenever oLVAL is low
//   oFVAL        out 1   frame valid
//   oLVAL        out 1   line valid
//   oFRAME_CONT  out 16  completed-frame count, bumps as FVAL falls
//   oBUSY        out 1   high in every state except IDLE
//   oFRAME_SUM   out 16  sum of the last frame's pixels mod 2^16 (0 if disabled)
module d5m_stream_gen
    import d5m_stream_gen_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 64,
    parameter int FRONT_PORCH = 16,
    parameter int BACK_PORCH  = 16,
    parameter int V_BLANK     = 200
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSTART,
    input  logic              iSTOP,
    input  logic [1:0]        iPATTERN,
    output logic [DATA_W-1:0] oDATA,
    output logic              oFVAL,
    output logic              oLVAL,
    output logic [15:0]       oFRAME_CONT,
    output logic              oBUSY,
    output logic [15:0]       oFRAME_SUM
);

    localparam logic [11:0] HA_LAST = 12'(H_ACTIVE - 1);
    localparam logic [11:0] VA_LAST = 12'(V_ACTIVE - 1);
    localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] FP_LAST = 16'(FRONT_PORCH - 1);
    localparam logic [15:0] BP_LAST = 16'(BACK_PORCH - 1);
    localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);

    state_t      state;
    logic [15:0] cnt;        // cycles spent in the current porch/blank state
    logic [11:0] x;
    logic [11:0] y;
    logic [1:0]  pat_q;
    logic        stop_flag;

    // Coordinates of the pixel that will be presented if the FSM is in LINE
    // after this edge; oDATA is registered, so the LUT looks one step ahead.
    logic [11:0]       pix_x;
    logic [11:0]       pix_y;
    logic [DATA_W-1:0] lut_pix;

    always_comb begin
        pix_x = (state == LINE)   ? x + 12'd1 : 12'd0;
        pix_y = (state == HBLANK) ? y + 12'd1 : y;
    end

    d5m_pattern_lut u_lut (
        .pattern (pat_q),
        .x       (pix_x),
        .y       (pix_y),
        .f       (oFRAME_CONT[3:0]),
        .pixel   (lut_pix)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= IDLE;
            cnt         <= '0;
            x           <= '0;
            y           <= '0;
            pat_q       <= '0;
            stop_flag   <= 1'b0;
            oDATA       <= '0;
            oFVAL       <= 1'b0;
            oLVAL       <= 1'b0;
            oFRAME_CONT <= '0;
            oBUSY       <= 1'b0;
        end else begin
            if (iSTOP) stop_flag <= 1'b1;
            case (state)
                IDLE: begin
                    if (iSTART) begin
                        state <= FRONT;
                        oFVAL <= 1'b1;
                        oBUSY <= 1'b1;
                        cnt   <= '0;
                        y     <= '0;
                        pat_q <= iPATTERN;
                    end
                end
                FRONT: begin
                    if (cnt == FP_LAST) begin
                        state <= LINE;
                        x     <= '0;
                        oLVAL <= 1'b1;
                        oDATA <= lut_pix;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                LINE: begin
                    if (x == HA_LAST) begin
                        state <= HBLANK;
                        cnt   <= '0;
                        oLVAL <= 1'b0;
                        oDATA <= '0;
                    end else begin
                        x     <= x + 12'd1;
                        oDATA <= lut_pix;
                    end
                end
                HBLANK: begin
                    if (cnt == HB_LAST) begin
                        cnt <= '0;
                        if (y < VA_LAST) begin
                            state <= LINE;
                            y     <= y + 12'd1;
                            x     <= '0;
                            oLVAL <= 1'b1;
                            oDATA <= lut_pix;
                        end else begin
                            state <= BACK;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                BACK: begin
                    if (cnt == BP_LAST) begin
                        state       <= VBLANK;
                        cnt         <= '0;
                        oFVAL       <= 1'b0;
                        oFRAME_CONT <= oFRAME_CONT + 16'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                VBLANK: begin
                    if (cnt == VB_LAST) begin
                        cnt <= '0;
                        // A stop arriving on this very cycle still counts.
                        if (stop_flag || iSTOP) begin
                            state     <= IDLE;
                            oBUSY     <= 1'b0;
                            stop_flag <= 1'b0;
                        end else begin
                            state <= FRONT;
                            oFVAL <= 1'b1;
                            y     <= '0;
                            pat_q <= iPATTERN;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    oFVAL <= 1'b0;
                    oLVAL <= 1'b0;
                    oDATA <= '0;
                    oBUSY <= 1'b0;
                end
            endcase
        end
    end

`ifdef STREAM_GEN_CHECKSUM_EN
    logic [15:0] acc;

    // The accumulator is held at zero while FVAL is low, so it is clear on
    // every entry to FRONT; it is published on the same edge FVAL falls.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            acc        <= '0;
            oFRAME_SUM <= '0;
        end else begin
            if (state == IDLE || state == VBLANK) begin
                acc <= '0;
            end else if (oLVAL) begin
                acc <= acc + 16'(oDATA);
            end
            if (state == BACK && cnt == BP_LAST) begin
                oFRAME_SUM <= acc;
            end
        end
    end
`else
    assign oFRAME_SUM = '0;
`endif

endmodule

// File: tb/tb_d5m_stream_gen.sv
// tb_d5m_stream_gen
// Self-checking bench for d5m_stream_gen with a small frame geometry.
// The reference model tracks only "running / offset into frame period" and
// derives FVAL, LVAL and pixel values arithmetically from the frame layout.
module tb_d5m_stream_gen;

    localparam int HA = 4;
    localparam int VA = 3;
    localparam int HB = 2;
    localparam int FP = 3;
    localparam int BP = 2;
    localparam int VB = 5;
    localparam int FV_LEN = FP + VA * (HA + HB) + BP;  // 23
    localparam int PERIOD = FV_LEN + VB;               // 28

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iSTART;
    logic        iSTOP;
    logic [1:0]  iPATTERN;
    logic [11:0] oDATA;
    logic        oFVAL;
    logic        oLVAL;
    logic [15:0] oFRAME_CONT;
    logic        oBUSY;
    logic [15:0] oFRAME_SUM;

    always #5 iCLK = ~iCLK;

    d5m_stream_gen #(
        .H_ACTIVE    (HA),
        .V_ACTIVE    (VA),
        .H_BLANK     (HB),
        .FRONT_PORCH (FP),
        .BACK_PORCH  (BP),
        .V_BLANK     (VB)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iSTART      (iSTART),
        .iSTOP       (iSTOP),
        .iPATTERN    (iPATTERN),
        .oDATA       (oDATA),
        .oFVAL       (oFVAL),
        .oLVAL       (oLVAL),
        .oFRAME_CONT (oFRAME_CONT),
        .oBUSY       (oBUSY),
        .oFRAME_SUM  (oFRAME_SUM)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    bit          m_run;
    bit          m_stop;
    int          m_t;
    logic [1:0]  m_pat;
    logic [15:0] m_f;
    logic [15:0] m_sum;
    int          fval_run;

    function automatic logic [11:0] ref_pix(input logic [1:0] pat, input int x,
                                            input int y, input logic [15:0] f);
        logic [3:0] xn;
        logic [3:0] yn;
        xn = 4'(x);
        yn = 4'(y);
        case (pat)
            2'd0: return 12'(x);
            2'd1: return 12'(y);
            2'd2: begin
                if (y % 2 == 0) return (x % 2 == 0) ? 12'h800 : 12'hFFF;
                else            return (x % 2 == 0) ? 12'h000 : 12'h800;
            end
            default: return {f[3:0], yn, xn};
        endcase
    endfunction

    function automatic logic [15:0] ref_frame_sum(input logic [1:0] pat,
                                                  input logic [15:0] f);
        logic [15:0] s;
        s = '0;
        for (int yy = 0; yy < VA; yy++)
            for (int xx = 0; xx < HA; xx++)
                s = s + 16'(ref_pix(pat, xx, yy, f));
        return s;
    endfunction

    task automatic exp_out(output logic fv, output logic lv, output logic [11:0] d);
        int u;
        int ln;
        int col;
        fv = 1'b0;
        lv = 1'b0;
        d  = '0;
        if (m_run && m_t < FV_LEN) begin
            fv = 1'b1;
            if (m_t >= FP) begin
                u   = m_t - FP;
                ln  = u / (HA + HB);
                col = u % (HA + HB);
                if (ln < VA && col < HA) begin
                    lv = 1'b1;
                    d  = ref_pix(m_pat, col, ln, m_f);
                end
            end
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_edge();
        if (iRST) begin
            m_run  = 1'b0;
            m_stop = 1'b0;
            m_t    = 0;
            m_pat  = '0;
            m_f    = '0;
            m_sum  = '0;
        end else begin
            if (iSTOP) m_stop = 1'b1;
            if (!m_run) begin
                if (iSTART) begin
                    m_run = 1'b1;
                    m_t   = 0;
                    m_pat = iPATTERN;
                end
            end else begin
                m_t++;
                if (m_t == FV_LEN) begin
`ifdef STREAM_GEN_CHECKSUM_EN
                    m_sum = ref_frame_sum(m_pat, m_f);
`endif
                    m_f = m_f + 16'd1;
                end
                if (m_t == PERIOD) begin
                    if (m_stop) begin
                        m_run  = 1'b0;
                        m_stop = 1'b0;
                    end else begin
                        m_t   = 0;
                        m_pat = iPATTERN;
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic        e_fv;
        logic        e_lv;
        logic [11:0] e_d;
        exp_out(e_fv, e_lv, e_d);
        check("fval",       16'(oFVAL),  16'(e_fv));
        check("lval",       16'(oLVAL),  16'(e_lv));
        check("data",       16'(oDATA),  16'(e_d));
        check("frame_cont", oFRAME_CONT, m_f);
        check("busy",       16'(oBUSY),  16'(m_run));
        check("frame_sum",  oFRAME_SUM,  m_sum);
        // Every completed FVAL pulse must have the full frame length.
        if (iRST) begin
            fval_run = 0;
        end else if (oFVAL) begin
            fval_run++;
        end else begin
            if (fval_run != 0) check("fval_len", 16'(fval_run), 16'(FV_LEN));
            fval_run = 0;
        end
    endtask

    task automatic step(input logic rst, input logic start, input logic stop,
                        input logic [1:0] pat);
        iRST     = rst;
        iSTART   = start;
        iSTOP    = stop;
        iPATTERN = pat;
        @(posedge iCLK);
        model_edge();
        @(negedge iCLK);
        check_all();
    endtask

    initial begin
        logic e_fv;
        logic e_lv;
        logic [11:0] e_d;
        bit   found;

        iRST = 1'b1; iSTART = 1'b0; iSTOP = 1'b0; iPATTERN = 2'd0;
        m_run = 1'b0; m_stop = 1'b0; m_t = 0; m_pat = '0; m_f = '0; m_sum = '0;
        fval_run = 0;

        // Reset state
        repeat (3) step(1'b1, 1'b0, 1'b0, 2'd0);
        repeat (6) step(1'b0, 1'b0, 1'b0, 2'd0);

        // Single ramp frame: start pulse, stop on the following cycle
        step(1'b0, 1'b1, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b1, 2'd0);
        repeat (40) step(1'b0, 1'b0, 1'b0, 2'd0);

        // Bayer frame, start and stop in the same idle cycle
        step(1'b0, 1'b1, 1'b1, 2'd2);
        repeat (35) step(1'b0, 1'b0, 1'b0, 2'd1);

        // Free-running tag pattern, stop during the third frame
        repeat (2 * PERIOD + 8) step(1'b0, 1'b1, 1'b0, 2'd3);
        step(1'b0, 1'b0, 1'b1, 2'd3);
        repeat (PERIOD + 10) step(1'b0, 1'b0, 1'b0, 2'd3);

        // Reset while LVAL is high, then a fresh full frame
        step(1'b0, 1'b1, 1'b0, 2'($urandom_range(0, 3)));
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, 1'b0, 1'b0, 2'd0);
            exp_out(e_fv, e_lv, e_d);
            if (e_lv && m_t > FP + HA) found = 1'b1;
        end
        check("mid_line_reached", 16'(found), 16'd1);
        step(1'b1, 1'b0, 1'b0, 2'd0);
        step(1'b0, 1'b1, 1'b1, 2'd0);
        repeat (35) step(1'b0, 1'b0, 1'b0, 2'd0);

        // Randomised traffic: held/dropped start, rare stops and resets,
        // pattern changing mid-frame
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 250) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 60) == 0,
                 2'($urandom_range(0, 3)));
        end

        // Drain: stop and wait (bounded) for the generator to go idle
        step(1'b0, 1'b0, 1'b1, 2'd0);
        for (int i = 0; i < 2 * PERIOD + 5 && oBUSY; i++) step(1'b0, 1'b0, 1'b0, 2'd0);
        check("drained_idle", 16'(oBUSY), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
